// File: rtl/defines_pkg.sv
// defines_pkg: opcode encodings shared by decode, register fetch and the even pipe
package defines_pkg;
  typedef enum logic [6:0] {
    NOP = 7'd0,
    ADD_WORD,
    ADD_HALFWORD,
    SUBTRACT_FROM_WORD,
    AND_WORD,
    OR_WORD,
    IMMEDIATE_LOAD_WORD,
    ADD_WORD_IMMEDIATE,
    MULTIPLY,
    FLOATING_ADD
  } Opcodes;
endpackage

// File: rtl/even_reg_fetch_if.sv
// even_reg_fetch_if: decode, writeback and issue signals around the even-pipe register fetch
interface even_reg_fetch_if #(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128
);
  logic                   dec_valid;
  defines_pkg::Opcodes    dec_opcode;
  logic [REG_ADDR_WD-1:0] dec_ra_addr, dec_rb_addr, dec_rc_addr, dec_rt_addr;
  logic [6:0]             dec_I7;
  logic [7:0]             dec_I8;
  logic [9:0]             dec_I10;
  logic [15:0]            dec_I16;
  logic [17:0]            dec_I18;
  logic                   stall, flush;
  logic                   wb_ep_en, wb_op_en;
  logic [REG_ADDR_WD-1:0] wb_ep_addr, wb_op_addr;
  logic [REG_DATA_WD-1:0] wb_ep_data, wb_op_data;
  defines_pkg::Opcodes    opcode;
  logic [REG_DATA_WD-1:0] out_RA, out_RB, out_RC;
  logic [6:0]             out_I7;
  logic [7:0]             out_I8;
  logic [9:0]             out_I10;
  logic [15:0]            out_I16;
  logic [17:0]            out_I18;
  logic [REG_ADDR_WD-1:0] out_RT_addr;
  modport master (
    output dec_valid, dec_opcode, dec_ra_addr, dec_rb_addr, dec_rc_addr, dec_rt_addr,
    output dec_I7, dec_I8, dec_I10, dec_I16, dec_I18, stall, flush,
    output wb_ep_en, wb_ep_addr, wb_ep_data, wb_op_en, wb_op_addr, wb_op_data,
    input  opcode, out_RA, out_RB, out_RC, out_I7, out_I8, out_I10, out_I16, out_I18, out_RT_addr
  );
  modport slave (
    input  dec_valid, dec_opcode, dec_ra_addr, dec_rb_addr, dec_rc_addr, dec_rt_addr,
    input  dec_I7, dec_I8, dec_I10, dec_I16, dec_I18, stall, flush,
    input  wb_ep_en, wb_ep_addr, wb_ep_data, wb_op_en, wb_op_addr, wb_op_data,
    output opcode, out_RA, out_RB, out_RC, out_I7, out_I8, out_I10, out_I16, out_I18, out_RT_addr
  );
endinterface

// File: rtl/even_reg_fetch.sv
// even_reg_fetch: 128x128 register file with bypassed operand fetch registered into the even pipe
module even_reg_fetch #(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128
) (
  input logic clk,
  input logic rst,
  even_reg_fetch_if.slave rf_if
);
  import defines_pkg::*;
  localparam int NREG = 1 << REG_ADDR_WD;
  typedef logic [REG_ADDR_WD-1:0] addr_t;
  typedef logic [REG_DATA_WD-1:0] data_t;
  data_t      rf_q [NREG];
  data_t      ra_q, rb_q, rc_q, ra_d, rb_d, rc_d;
  addr_t      ra_addr_q, rb_addr_q, rc_addr_q, ra_addr_d, rb_addr_d, rc_addr_d;
  addr_t      rt_q, rt_d;
  Opcodes     op_q, op_d;
  logic [6:0]  i7_q, i7_d;
  logic [7:0]  i8_q, i8_d;
  logic [9:0]  i10_q, i10_d;
  logic [15:0] i16_q, i16_d;
  logic [17:0] i18_q, i18_d;
  logic  ep_en, op_en;
  addr_t ep_a, op_a;
  data_t ep_dat, op_dat;

  assign ep_en  = rf_if.wb_ep_en;
  assign ep_a   = rf_if.wb_ep_addr;
  assign ep_dat = rf_if.wb_ep_data;
  assign op_en  = rf_if.wb_op_en;
  assign op_a   = rf_if.wb_op_addr;
  assign op_dat = rf_if.wb_op_data;

  // even writeback beats odd writeback, which beats the stored value
  function automatic data_t fwd(input addr_t a, input data_t dflt);
    return (ep_en && ep_a == a) ? ep_dat : (op_en && op_a == a) ? op_dat : dflt;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (op_en) rf_q[op_a] <= op_dat;
      if (ep_en) rf_q[ep_a] <= ep_dat;
    end
  end

  always_comb begin
    op_d      = NOP;
    rt_d      = '0;
    i7_d      = '0;
    i8_d      = '0;
    i10_d     = '0;
    i16_d     = '0;
    i18_d     = '0;
    ra_d      = '0;
    rb_d      = '0;
    rc_d      = '0;
    ra_addr_d = '0;
    rb_addr_d = '0;
    rc_addr_d = '0;
    if (!rf_if.flush && rf_if.stall) begin
      op_d      = op_q;
      rt_d      = rt_q;
      i7_d      = i7_q;
      i8_d      = i8_q;
      i10_d     = i10_q;
      i16_d     = i16_q;
      i18_d     = i18_q;
      ra_addr_d = ra_addr_q;
      rb_addr_d = rb_addr_q;
      rc_addr_d = rc_addr_q;
      ra_d      = fwd(ra_addr_q, ra_q);
      rb_d      = fwd(rb_addr_q, rb_q);
      rc_d      = fwd(rc_addr_q, rc_q);
    end else if (!rf_if.flush && rf_if.dec_valid) begin
      op_d      = rf_if.dec_opcode;
      rt_d      = rf_if.dec_rt_addr;
      i7_d      = rf_if.dec_I7;
      i8_d      = rf_if.dec_I8;
      i10_d     = rf_if.dec_I10;
      i16_d     = rf_if.dec_I16;
      i18_d     = rf_if.dec_I18;
      ra_addr_d = rf_if.dec_ra_addr;
      rb_addr_d = rf_if.dec_rb_addr;
      rc_addr_d = rf_if.dec_rc_addr;
      ra_d      = fwd(rf_if.dec_ra_addr, rf_q[rf_if.dec_ra_addr]);
      rb_d      = fwd(rf_if.dec_rb_addr, rf_q[rf_if.dec_rb_addr]);
      rc_d      = fwd(rf_if.dec_rc_addr, rf_q[rf_if.dec_rc_addr]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q      <= NOP;
      rt_q      <= '0;
      i7_q      <= '0;
      i8_q      <= '0;
      i10_q     <= '0;
      i16_q     <= '0;
      i18_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      ra_addr_q <= '0;
      rb_addr_q <= '0;
      rc_addr_q <= '0;
    end else begin
      op_q      <= op_d;
      rt_q      <= rt_d;
      i7_q      <= i7_d;
      i8_q      <= i8_d;
      i10_q     <= i10_d;
      i16_q     <= i16_d;
      i18_q     <= i18_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      ra_addr_q <= ra_addr_d;
      rb_addr_q <= rb_addr_d;
      rc_addr_q <= rc_addr_d;
    end
  end

  assign rf_if.opcode      = op_q;
  assign rf_if.out_RT_addr = rt_q;
  assign rf_if.out_I7      = i7_q;
  assign rf_if.out_I8      = i8_q;
  assign rf_if.out_I10     = i10_q;
  assign rf_if.out_I16     = i16_q;
  assign rf_if.out_I18     = i18_q;
  assign rf_if.out_RA      = ra_q;
  assign rf_if.out_RB      = rb_q;
  assign rf_if.out_RC      = rc_q;
endmodule

// File: tb/tb_even_reg_fetch.sv
// tb_even_reg_fetch: directed and randomized checks of even_reg_fetch against a register-file model
module tb_even_reg_fetch;
  import defines_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  even_reg_fetch_if #(.REG_ADDR_WD(7), .REG_DATA_WD(128)) bus ();
  even_reg_fetch #(.REG_ADDR_WD(7), .REG_DATA_WD(128)) dut (.clk(clk), .rst(rst), .rf_if(bus));

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  logic [127:0] mem [128];
  Opcodes e_op;
  logic [6:0] e_rt, e_ra, e_rb, e_rc, e_i7;
  logic [7:0] e_i8;
  logic [9:0] e_i10;
  logic [15:0] e_i16;
  logic [17:0] e_i18;
  logic e_valid, e_fresh;
  Opcodes ops [10] = '{NOP, ADD_WORD, ADD_HALFWORD, SUBTRACT_FROM_WORD, AND_WORD, OR_WORD,
                      IMMEDIATE_LOAD_WORD, ADD_WORD_IMMEDIATE, MULTIPLY, FLOATING_ADD};
  logic [6:0] pool [4] = '{7'd0, 7'd1, 7'd2, 7'd127};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Model: an issued instruction's operands always equal the architectural register value after the edge.
  always @(posedge clk) begin
    if (!rst) begin
      foreach (mem[i]) mem[i] = '0;
      e_op = NOP; e_rt = 0; e_i7 = 0; e_i8 = 0; e_i10 = 0; e_i16 = 0; e_i18 = 0;
      e_ra = 0; e_rb = 0; e_rc = 0; e_valid = 0; e_fresh = 1;
    end else begin
      if (bus.wb_op_en) mem[bus.wb_op_addr] = bus.wb_op_data;
      if (bus.wb_ep_en) mem[bus.wb_ep_addr] = bus.wb_ep_data;
      if (bus.flush || (!bus.stall && !bus.dec_valid)) begin
        e_op = NOP; e_rt = 0; e_i7 = 0; e_i8 = 0; e_i10 = 0; e_i16 = 0; e_i18 = 0;
        e_valid = 0; e_fresh = 1;
      end else if (bus.stall) begin
        e_fresh = 0;
      end else begin
        e_op = bus.dec_opcode; e_rt = bus.dec_rt_addr;
        e_i7 = bus.dec_I7; e_i8 = bus.dec_I8; e_i10 = bus.dec_I10; e_i16 = bus.dec_I16; e_i18 = bus.dec_I18;
        e_ra = bus.dec_ra_addr; e_rb = bus.dec_rb_addr; e_rc = bus.dec_rc_addr;
        e_valid = 1; e_fresh = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("opcode", bus.opcode, e_op);
      chk("rt_addr", bus.out_RT_addr, e_rt);
      chk("i7", bus.out_I7, e_i7);
      chk("i8", bus.out_I8, e_i8);
      chk("i10", bus.out_I10, e_i10);
      chk("i16", bus.out_I16, e_i16);
      chk("i18", bus.out_I18, e_i18);
      if (e_valid) begin
        chk("RA", bus.out_RA, mem[e_ra]);
        chk("RB", bus.out_RB, mem[e_rb]);
        chk("RC", bus.out_RC, mem[e_rc]);
      end else if (e_fresh) begin
        chk("RA_bubble", bus.out_RA, 0);
        chk("RB_bubble", bus.out_RB, 0);
        chk("RC_bubble", bus.out_RC, 0);
      end
    end
  end

  task automatic idle();
    bus.dec_valid = 0; bus.dec_opcode = NOP;
    bus.dec_ra_addr = 0; bus.dec_rb_addr = 0; bus.dec_rc_addr = 0; bus.dec_rt_addr = 0;
    bus.dec_I7 = 0; bus.dec_I8 = 0; bus.dec_I10 = 0; bus.dec_I16 = 0; bus.dec_I18 = 0;
    bus.stall = 0; bus.flush = 0;
    bus.wb_ep_en = 0; bus.wb_ep_addr = 0; bus.wb_ep_data = 0;
    bus.wb_op_en = 0; bus.wb_op_addr = 0; bus.wb_op_data = 0;
  endtask

  task automatic issue(input Opcodes op, input logic [6:0] ra, rb, rc, rt);
    bus.dec_valid = 1; bus.dec_opcode = op;
    bus.dec_ra_addr = ra; bus.dec_rb_addr = rb; bus.dec_rc_addr = rc; bus.dec_rt_addr = rt;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] pick();
    return ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : pool[$urandom_range(0, 3)];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    idle();
    rst = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_opcode", bus.opcode, NOP);
    chk("reset_RA", bus.out_RA, 0);
    rst = 1;
    issue(ADD_WORD, 7'd5, 7'd0, 7'd0, 7'd0);
    edge1();
    chk("read_r5_op", bus.opcode, ADD_WORD);
    chk("read_r5_RA", bus.out_RA, 0);
    @(negedge clk); idle();
    bus.wb_op_en = 1; bus.wb_op_addr = 10; bus.wb_op_data = 128'h1;
    @(negedge clk); idle();
    issue(ADD_WORD, 7'd10, 7'd0, 7'd0, 7'd0);
    edge1();
    chk("wr_rd_r10", bus.out_RA, 128'h1);
    @(negedge clk); idle();
    bus.wb_ep_en = 1; bus.wb_ep_addr = 3; bus.wb_ep_data = 128'hA5;
    bus.wb_op_en = 1; bus.wb_op_addr = 3; bus.wb_op_data = 128'h5A;
    issue(ADD_WORD, 7'd3, 7'd3, 7'd0, 7'd0);
    edge1();
    chk("collide_RA", bus.out_RA, 128'hA5);
    chk("collide_RB", bus.out_RB, 128'hA5);
    @(negedge clk); idle();
    issue(ADD_WORD, 7'd0, 7'd0, 7'd3, 7'd0);
    edge1();
    chk("collide_later_RC", bus.out_RC, 128'hA5);
    @(negedge clk); idle();
    issue(ADD_WORD, 7'd7, 7'd0, 7'd0, 7'd9);
    edge1();
    chk("stall_pre_RA", bus.out_RA, 0);
    @(negedge clk); idle();
    bus.stall = 1;
    issue(OR_WORD, 7'd1, 7'd1, 7'd1, 7'd2);
    bus.wb_op_en = 1; bus.wb_op_addr = 7; bus.wb_op_data = 128'hFF;
    edge1();
    chk("stall_refresh_RA", bus.out_RA, 128'hFF);
    chk("stall_hold_op", bus.opcode, ADD_WORD);
    chk("stall_hold_rt", bus.out_RT_addr, 9);
    @(negedge clk); idle();
    issue(AND_WORD, 7'd10, 7'd0, 7'd0, 7'd4);
    edge1();
    chk("unstall_op", bus.opcode, AND_WORD);
    chk("unstall_RA", bus.out_RA, 128'h1);
    @(negedge clk); idle();
    bus.stall = 1; bus.flush = 1;
    bus.wb_ep_en = 1; bus.wb_ep_addr = 20; bus.wb_ep_data = 128'h1234;
    edge1();
    chk("flush_op", bus.opcode, NOP);
    chk("flush_rt", bus.out_RT_addr, 0);
    @(negedge clk); idle();
    issue(ADD_WORD, 7'd20, 7'd0, 7'd0, 7'd0);
    edge1();
    chk("flush_wb_kept", bus.out_RA, 128'h1234);
    @(negedge clk); idle();
    issue(IMMEDIATE_LOAD_WORD, 7'd0, 7'd0, 7'd0, 7'd33);
    bus.dec_I16 = 16'h8001;
    edge1();
    chk("imm_I16", bus.out_I16, 128'h8001);
    chk("imm_rt", bus.out_RT_addr, 33);
    chk("imm_op", bus.opcode, IMMEDIATE_LOAD_WORD);
    @(negedge clk); idle();
    bus.wb_ep_en = 1; bus.wb_ep_addr = 127; bus.wb_ep_data = 128'hDEAD;
    bus.wb_op_en = 1; bus.wb_op_addr = 0; bus.wb_op_data = 128'hBEEF;
    @(negedge clk); idle();
    issue(ADD_WORD, 7'd127, 7'd0, 7'd127, 7'd1);
    edge1();
    chk("r127", bus.out_RA, 128'hDEAD);
    chk("r0", bus.out_RB, 128'hBEEF);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) != 0);
      bus.dec_valid = ($urandom_range(0, 3) != 0);
      bus.dec_opcode = ops[$urandom_range(0, 9)];
      bus.dec_ra_addr = pick(); bus.dec_rb_addr = pick(); bus.dec_rc_addr = pick(); bus.dec_rt_addr = pick();
      bus.dec_I7 = 7'($urandom()); bus.dec_I8 = 8'($urandom()); bus.dec_I10 = 10'($urandom());
      bus.dec_I16 = 16'($urandom()); bus.dec_I18 = 18'($urandom());
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      bus.wb_ep_en = $urandom_range(0, 1) == 1; bus.wb_ep_addr = pick(); bus.wb_ep_data = rnd128();
      bus.wb_op_en = $urandom_range(0, 1) == 1; bus.wb_op_addr = pick(); bus.wb_op_data = rnd128();
    end
    @(negedge clk);
    idle();
    rst = 1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
